pfd_lock_detect: RTL and testbench

//  Lock detector downstream of the PFD. Consumes the PFD up/down pulses, measures phase-error

---
 rtl/pfd_lock_detect.sv | 211 +++++++++++++++++++++
 tb/tb_pfd_lock_detect.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pfd_lock_detect.sv
// PFD lock detector: oversamples up/down, counts error samples per window, runs the lock FSM.
// Optional signed-error output enabled by defining LOCKDET_SIGNED_ERR_EN.
module pfd_lock_detect #(
  parameter int WIN_CYC    = 64,
  parameter int ERR_THR    = 4,
  parameter int UNLOCK_THR = 16,
  parameter int LOCK_WINS  = 8,
  parameter int MISS_MAX   = 2,
  localparam int CNT_W     = $clog2(WIN_CYC + 1)
) (
  input  logic             sampclk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             down,
  output logic             lock,
  output logic             lock_lost,
  output logic             win_valid,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       state
`ifdef LOCKDET_SIGNED_ERR_EN
  , output logic signed [CNT_W:0] err_sgn
`endif
);

  localparam int GC_W = (LOCK_WINS > 1) ? $clog2(LOCK_WINS + 1) : 1;
  localparam int MS_W = $clog2(MISS_MAX + 2);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN_CYC - 1);
  localparam logic [GC_W-1:0]  GC_ZERO  = {GC_W{1'b0}};
  localparam logic [GC_W-1:0]  GC_ONE   = GC_W'(1);
  localparam logic [MS_W-1:0]  MS_ZERO  = {MS_W{1'b0}};
  localparam logic [MS_W-1:0]  MS_ONE   = MS_W'(1);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2,
    HOLD     = 2'd3
  } lk_state_t;

  logic             up_meta_r, up_sync_r, down_meta_r, down_sync_r;
  logic [CNT_W-1:0] wcnt_r, acc_r;
  logic [GC_W-1:0]  good_cnt_r, good_cnt_nx_s;
  logic [MS_W-1:0]  miss_r, miss_nx_s;
  lk_state_t        state_r, state_nx_s;
  logic             err_s, close_s, good_s, gross_s, lost_nx_s, lock_nx_s;
  logic [CNT_W-1:0] e_s;

  // Overlapping up/down cancel: only exclusive activity is a phase error.
  assign err_s   = up_sync_r ^ down_sync_r;
  assign close_s = en & (wcnt_r == WIN_LAST);
  assign e_s     = acc_r + {{(CNT_W-1){1'b0}}, err_s};
  assign good_s  = (int'(e_s) <= ERR_THR);
  assign gross_s = (int'(e_s) > UNLOCK_THR);
  assign state   = state_r;

  // Two-flop synchronizers for the asynchronous PFD pulses.
  always_ff @(posedge sampclk) begin
    if (!rst_n) begin
      up_meta_r   <= 1'b0;
      up_sync_r   <= 1'b0;
      down_meta_r <= 1'b0;
      down_sync_r <= 1'b0;
    end else begin
      up_meta_r   <= up;
      up_sync_r   <= up_meta_r;
      down_meta_r <= down;
      down_sync_r <= down_meta_r;
    end
  end

  // Window counter and error accumulator; publishes the count at window close.
  always_ff @(posedge sampclk) begin
    if (!rst_n) begin
      wcnt_r    <= CNT_ZERO;
      acc_r     <= CNT_ZERO;
      err_cnt   <= CNT_ZERO;
      win_valid <= 1'b0;
    end else if (en) begin
      win_valid <= close_s;
      if (close_s) begin
        wcnt_r  <= CNT_ZERO;
        acc_r   <= CNT_ZERO;
        err_cnt <= e_s;
      end else begin
        wcnt_r <= wcnt_r + CNT_W'(1);
        acc_r  <= e_s;
      end
    end else begin
      win_valid <= 1'b0;
    end
  end

  // Lock FSM next state, stepped only at window close.
  always_comb begin
    state_nx_s    = state_r;
    good_cnt_nx_s = good_cnt_r;
    miss_nx_s     = miss_r;
    if (close_s) begin
      case (state_r)
        UNLOCKED: begin
          if (good_s) begin
            if (LOCK_WINS == 1) begin
              state_nx_s    = LOCKED;
              good_cnt_nx_s = GC_ZERO;
            end else begin
              state_nx_s    = ACQUIRE;
              good_cnt_nx_s = GC_ONE;
            end
          end else begin
            state_nx_s = UNLOCKED;
          end
        end
        ACQUIRE: begin
          if (!good_s) begin
            state_nx_s = UNLOCKED;
          end else if (int'(good_cnt_r) + 1 >= LOCK_WINS) begin
            state_nx_s    = LOCKED;
            good_cnt_nx_s = GC_ZERO;
          end else begin
            good_cnt_nx_s = good_cnt_r + GC_ONE;
          end
        end
        LOCKED: begin
          if (gross_s) begin
            state_nx_s = UNLOCKED;
          end else if (good_s) begin
            miss_nx_s = MS_ZERO;
          end else if (MISS_MAX == 0) begin
            state_nx_s = UNLOCKED;
          end else begin
            state_nx_s = HOLD;
            miss_nx_s  = MS_ONE;
          end
        end
        HOLD: begin
          if (gross_s) begin
            state_nx_s = UNLOCKED;
          end else if (good_s) begin
            state_nx_s = LOCKED;
            miss_nx_s  = MS_ZERO;
          end else if (int'(miss_r) + 1 > MISS_MAX) begin
            state_nx_s = UNLOCKED;
          end else begin
            miss_nx_s = miss_r + MS_ONE;
          end
        end
        default: state_nx_s = UNLOCKED;
      endcase
      if (state_nx_s == UNLOCKED) begin
        good_cnt_nx_s = GC_ZERO;
        miss_nx_s     = MS_ZERO;
      end else begin
        good_cnt_nx_s = good_cnt_nx_s;
      end
    end else begin
      state_nx_s = state_r;
    end
    lock_nx_s = (state_nx_s == LOCKED) || (state_nx_s == HOLD);
    lost_nx_s = ((state_r == LOCKED) || (state_r == HOLD)) && (state_nx_s == UNLOCKED);
  end

  // Lock FSM state and registered status outputs.
  always_ff @(posedge sampclk) begin
    if (!rst_n) begin
      state_r    <= UNLOCKED;
      good_cnt_r <= GC_ZERO;
      miss_r     <= MS_ZERO;
      lock       <= 1'b0;
      lock_lost  <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      good_cnt_r <= good_cnt_nx_s;
      miss_r     <= miss_nx_s;
      lock       <= lock_nx_s;
      lock_lost  <= lost_nx_s;
    end
  end

`ifdef LOCKDET_SIGNED_ERR_EN
  logic signed [CNT_W:0] sacc_r, sinc_s;

  // Signed step: +1 for up-only, -1 for down-only, 0 otherwise.
  always_comb begin
    if (up_sync_r & ~down_sync_r) begin
      sinc_s = {{CNT_W{1'b0}}, 1'b1};
    end else if (down_sync_r & ~up_sync_r) begin
      sinc_s = {(CNT_W+1){1'b1}};
    end else begin
      sinc_s = {(CNT_W+1){1'b0}};
    end
  end

  // Signed accumulator tracking loop polarity, published alongside err_cnt.
  always_ff @(posedge sampclk) begin
    if (!rst_n) begin
      sacc_r  <= {(CNT_W+1){1'b0}};
      err_sgn <= {(CNT_W+1){1'b0}};
    end else if (close_s) begin
      sacc_r  <= {(CNT_W+1){1'b0}};
      err_sgn <= sacc_r + sinc_s;
    end else if (en) begin
      sacc_r <= sacc_r + sinc_s;
    end
  end
`else
  // Signed-error tracking not built.
`endif

endmodule

// File: tb/tb_pfd_lock_detect.sv
// Directed self-checking bench for pfd_lock_detect (default parameters).
module tb_pfd_lock_detect;
  localparam int CNT_W = 7;

  logic             sampclk = 1'b0;
  logic             rst_n, en, up, down;
  logic             lock, lock_lost, win_valid;
  logic [CNT_W-1:0] err_cnt;
  logic [1:0]       state;
  logic signed [CNT_W:0] es_obs;
`ifdef LOCKDET_SIGNED_ERR_EN
  logic signed [CNT_W:0] err_sgn;
`endif

  int vec_cnt     = 0;
  int miscompares = 0;

  pfd_lock_detect dut (
    .sampclk(sampclk), .rst_n(rst_n), .en(en), .up(up), .down(down),
    .lock(lock), .lock_lost(lock_lost), .win_valid(win_valid),
    .err_cnt(err_cnt), .state(state)
`ifdef LOCKDET_SIGNED_ERR_EN
    , .err_sgn(err_sgn)
`endif
  );

  always #5 sampclk = ~sampclk;

  task automatic tick;
    @(posedge sampclk);
    #1;
  endtask

  // One aligned 64-cycle window; up/down high for [start, start+len) of the window.
  task automatic run_window(input int us, input int ul, input int ds, input int dl,
                            output logic wv0, output logic ll0, output logic wv,
                            output logic ll, output logic lk, output logic [1:0] st,
                            output logic [CNT_W-1:0] ec);
    for (int i = 0; i < 64; i++) begin
      up   = (i >= us) && (i < us + ul);
      down = (i >= ds) && (i < ds + dl);
      tick();
      if (i == 0) begin
        wv0 = win_valid;
        ll0 = lock_lost;
      end
    end
    up = 1'b0; down = 1'b0;
    wv = win_valid; ll = lock_lost; lk = lock; st = state; ec = err_cnt;
    es_obs = '0;
`ifdef LOCKDET_SIGNED_ERR_EN
    es_obs = err_sgn;
`endif
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b1; up = 1'b1; down = 1'b0;
    repeat (3) tick();
    vec_cnt++; if (lock !== 1'b0) begin miscompares++; $display("FAIL rst_lock: got %b want 0", lock); end
    vec_cnt++; if (err_cnt !== 7'd0) begin miscompares++; $display("FAIL rst_err_cnt: got %0d want 0", err_cnt); end
    vec_cnt++; if (win_valid !== 1'b0) begin miscompares++; $display("FAIL rst_win_valid: got %b want 0", win_valid); end
    vec_cnt++; if (state !== 2'd0) begin miscompares++; $display("FAIL rst_state: got %0d want 0", state); end
    vec_cnt++; if (lock_lost !== 1'b0) begin miscompares++; $display("FAIL rst_lock_lost: got %b want 0", lock_lost); end
`ifdef LOCKDET_SIGNED_ERR_EN
    vec_cnt++; if (err_sgn !== 8'sd0) begin miscompares++; $display("FAIL rst_err_sgn: got %0d want 0", err_sgn); end
`endif
    up = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_acquire;
    logic wv0, ll0, wv, ll, lk; logic [1:0] st, exp_st; logic [CNT_W-1:0] ec;
    for (int w = 1; w <= 8; w++) begin
      run_window(0, 0, 0, 0, wv0, ll0, wv, ll, lk, st, ec);
      exp_st = (w < 8) ? 2'd1 : 2'd2;
      vec_cnt++; if (wv !== 1'b1 || wv0 !== 1'b0) begin miscompares++; $display("FAIL acq_win_valid w%0d: got %b/%b want 0/1", w, wv0, wv); end
      vec_cnt++; if (st !== exp_st) begin miscompares++; $display("FAIL acq_state w%0d: got %0d want %0d", w, st, exp_st); end
      vec_cnt++; if (lk !== (w == 8)) begin miscompares++; $display("FAIL acq_lock w%0d: got %b want %b", w, lk, w == 8); end
      vec_cnt++; if (ec !== 7'd0 || ll !== 1'b0 || ll0 !== 1'b0) begin miscompares++; $display("FAIL acq_misc w%0d: got err=%0d ll=%b/%b want 0,0/0", w, ec, ll0, ll); end
    end
  endtask

  task automatic test_hold_unlock;
    logic wv0, ll0, wv, ll, lk; logic [1:0] st; logic [CNT_W-1:0] ec;
    logic [1:0] exp_st [3] = '{2'd3, 2'd3, 2'd0};
    for (int w = 0; w < 3; w++) begin
      run_window(10, 10, 0, 0, wv0, ll0, wv, ll, lk, st, ec);
      vec_cnt++; if (st !== exp_st[w]) begin miscompares++; $display("FAIL hold_state w%0d: got %0d want %0d", w, st, exp_st[w]); end
      vec_cnt++; if (ll !== (w == 2) || ll0 !== 1'b0) begin miscompares++; $display("FAIL hold_lock_lost w%0d: got %b want %b", w, ll, w == 2); end
      vec_cnt++; if (lk !== (w < 2)) begin miscompares++; $display("FAIL hold_lock w%0d: got %b want %b", w, lk, w < 2); end
      vec_cnt++; if (ec !== 7'd10) begin miscompares++; $display("FAIL hold_err_cnt w%0d: got %0d want 10", w, ec); end
    end
  endtask

  task automatic test_gross;
    logic wv0, ll0, wv, ll, lk; logic [1:0] st; logic [CNT_W-1:0] ec;
    run_window(0, 0, 10, 20, wv0, ll0, wv, ll, lk, st, ec);
    vec_cnt++; if (st !== 2'd0) begin miscompares++; $display("FAIL gross_state: got %0d want 0", st); end
    vec_cnt++; if (ll !== 1'b1 || lk !== 1'b0) begin miscompares++; $display("FAIL gross_flags: got ll=%b lock=%b want 1,0", ll, lk); end
    vec_cnt++; if (ec !== 7'd20) begin miscompares++; $display("FAIL gross_err_cnt: got %0d want 20", ec); end
  endtask

  // Boundaries: 4 good, 5 and 16 bad, 17 gross.
  task automatic test_thresholds;
    logic wv0, ll0, wv, ll, lk; logic [1:0] st; logic [CNT_W-1:0] ec;
    int         widths [5] = '{4, 16, 4, 5, 17};
    logic [1:0] exp_st [5] = '{2'd2, 2'd3, 2'd2, 2'd3, 2'd0};
    for (int w = 0; w < 5; w++) begin
      run_window(10, widths[w], 0, 0, wv0, ll0, wv, ll, lk, st, ec);
      vec_cnt++; if (int'(ec) != widths[w]) begin miscompares++; $display("FAIL thr_err_cnt w%0d: got %0d want %0d", w, ec, widths[w]); end
      vec_cnt++; if (st !== exp_st[w]) begin miscompares++; $display("FAIL thr_state w%0d: got %0d want %0d", w, st, exp_st[w]); end
      vec_cnt++; if (ll !== (w == 4)) begin miscompares++; $display("FAIL thr_lock_lost w%0d: got %b want %b", w, ll, w == 4); end
    end
  endtask

  task automatic test_overlap_enable;
    logic wv0, ll0, wv, ll, lk; logic [1:0] st; logic [CNT_W-1:0] ec;
    run_window(0, 64, 0, 64, wv0, ll0, wv, ll, lk, st, ec);
    vec_cnt++; if (ec !== 7'd0) begin miscompares++; $display("FAIL overlap_err_cnt: got %0d want 0", ec); end
    vec_cnt++; if (st !== 2'd2 || lk !== 1'b1) begin miscompares++; $display("FAIL overlap_lock: got state=%0d lock=%b want 2,1", st, lk); end
    for (int i = 0; i < 94; i++) begin
      en = !((i >= 20) && (i < 50));
      up = (i >= 25) && (i < 35);
      tick();
      if (i == 63) begin
        vec_cnt++; if (win_valid !== 1'b0) begin miscompares++; $display("FAIL en_early_close: got %b want 0", win_valid); end
      end else if (i == 93) begin
        vec_cnt++; if (win_valid !== 1'b1) begin miscompares++; $display("FAIL en_late_close: got %b want 1", win_valid); end
        vec_cnt++; if (err_cnt !== 7'd0 || state !== 2'd2) begin miscompares++; $display("FAIL en_frozen_acc: got err=%0d state=%0d want 0,2", err_cnt, state); end
      end
    end
    en = 1'b1; up = 1'b0;
  endtask

  task automatic test_signed;
    logic wv0, ll0, wv, ll, lk; logic [1:0] st; logic [CNT_W-1:0] ec;
    run_window(10, 5, 30, 3, wv0, ll0, wv, ll, lk, st, ec);
    vec_cnt++; if (ec !== 7'd8 || st !== 2'd3) begin miscompares++; $display("FAIL mix_err_cnt: got err=%0d state=%0d want 8,3", ec, st); end
`ifdef LOCKDET_SIGNED_ERR_EN
    vec_cnt++; if (es_obs !== 8'sd2) begin miscompares++; $display("FAIL sgn_pos: got %0d want 2", es_obs); end
`endif
    run_window(40, 2, 10, 7, wv0, ll0, wv, ll, lk, st, ec);
    vec_cnt++; if (ec !== 7'd9 || st !== 2'd3) begin miscompares++; $display("FAIL mix2_err_cnt: got err=%0d state=%0d want 9,3", ec, st); end
`ifdef LOCKDET_SIGNED_ERR_EN
    vec_cnt++; if (es_obs !== -8'sd5) begin miscompares++; $display("FAIL sgn_neg: got %0d want -5", es_obs); end
`endif
    up = 1'b1;
    repeat (20) tick();
    test_reset();
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_hold_unlock();
    test_acquire();
    test_gross();
    test_acquire();
    test_thresholds();
    test_acquire();
    test_overlap_enable();
    test_signed();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end
endmodule
